llr_window_buf: RTL and testbench
=================================

# llr_window_buf

Parametrised LLR staging buffer between the channel-input interface and the decoder datapath. It accepts framed LLR words under a valid/ready handshake and converts each lane from sign-magnitude to two's complement. It holds one codeword of up to DEPTH LLRs, rotates the codeword by WIN positions in either direction, and serves NRD registered random reads from the front window. It generalises the fixed 8-lane, 4-port, 1024-deep LLR memory with:
- configurable width and depth;
- a load handshake with frame completion and release;
- bidirectional rotation with a segment index.

## Interface
Parameters:
- LANES, 8: LLRs per input word.
- LLR_W, 7: stored LLR width, two's complement; input lane width is LLR_W+1 (sign-magnitude).
- DEPTH, 1024: maximum codeword length; power of two, at least 16*LANES.
- WIN, 128: front-window size and rotation step; power of two, at most DEPTH/8.
- NRD, 4: read ports.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_code  in  2  code length: 0 gives N=DEPTH/16, 1 gives N=DEPTH/4, 2 gives N=DEPTH, 3 is reserved.
- i_in_valid  in  1  input word valid.
- o_in_ready  out  1  buffer accepts a word.
- i_in_data  in  LANES*(LLR_W+1)  lane k occupies bits [k*(LLR_W+1) +: LLR_W+1]; the MSB of each lane is the sign.
- o_loaded  out  1  full frame held.
- i_release  in  1  drop the frame and re-arm loading.
- i_rot_req  in  1  rotate by WIN.
- i_rot_dir  in  1  0 = forward (toward the front), 1 = backward.
- o_seg  out  log2(DEPTH/WIN)  index of the WIN-segment currently at the front.
- i_rd_en  in  1  read strobe.
- i_rd_pos  in  NRD*log2(WIN)  per-port front-window positions.
- o_rd_data  out  NRD*LLR_W  read data.
- o_rd_valid  out  1  read data valid.

## Operation
- States: LOAD and HOLD. Reset enters LOAD with word counter 0.
- i_code is latched when the first word of a frame is accepted. The latched value governs N until release.
- o_in_ready is 1 in LOAD when code is not 3. It is 0 in HOLD, and 0 in LOAD while i_code==3 before the first word.
- Accept (valid & ready):
  - Lane k is converted and written to mem[k].
  - mem[i] takes mem[i-LANES] for LANES ≤ i < N.
  - Entries at N and above are unchanged.
  - Word counter increments.
- Conversion: value = sign ? -mag : mag, computed modulo 2^LLR_W.
- Frame completion: the acceptance of word N/LANES moves the state to HOLD, sets o_loaded, clears o_seg, and clears the counter. The first accepted word then sits at mem[N-LANES .. N-1].
- Rotation applies in HOLD only, and only when N > WIN:
  - Forward: mem'[i] = mem[(i+WIN) mod N]; o_seg increments modulo N/WIN.
  - Backward: mem'[i] = mem[(i-WIN+N) mod N]; o_seg decrements modulo N/WIN.
  - Entries at N and above are unchanged.
- i_rot_req is ignored in LOAD, and ignored when N ≤ WIN.
- i_release in HOLD returns to LOAD and clears o_loaded. Memory contents are kept; they are overwritten by the next frame.
- When i_release and i_rot_req are high in the same cycle, release wins and no rotation occurs.
- i_release in LOAD is ignored.
- Reads: port p returns mem[i_rd_pos[p]], sampled from the pre-update contents of the same cycle. Positions at N and above, when N < WIN, return stale contents. Reads are legal in any state.

## Timing
- Reset: o_in_ready=0 during reset, o_loaded=0, o_seg=0, o_rd_data=0, o_rd_valid=0, all memory entries 0. o_in_ready rises in the first cycle after deassertion when i_code≠3.
- Accept, rotate and release each take effect at the next rising edge.
- o_loaded rises in the cycle after the last word is accepted. o_in_ready is 0 in that same cycle, so there are no back-to-back frames without a release.
- Reads have a fixed latency of 1. o_rd_data and o_rd_valid register i_rd_en and the addressed data. o_rd_data holds its value when i_rd_en=0.
- A read issued in the same cycle as a rotation returns pre-rotation data.
- Reset asserted mid-load or mid-hold aborts immediately and returns to the reset values.

## Configuration
- LLR_BUF_SAT_EN defined: the input magnitude is clipped to 2^(LLR_W-1)-1 before conversion, so the stored value lies in [-(2^(LLR_W-1)-1), 2^(LLR_W-1)-1].
- LLR_BUF_SAT_EN undefined: conversion wraps modulo 2^LLR_W, with no clip logic.

## Structure
- Shared package holds:
  - code-length encodings and the N-from-code function;
  - lane and port width localparams derived from the parameters;
  - the state enum (LOAD, HOLD).
- One sub-module, llr_sm2tc: a single-lane sign-magnitude to two's-complement converter, carrying the LLR_BUF_SAT_EN clip. It is instantiated LANES times.
- Memory, load FSM, rotation mux and read registers live in the top level.

## Test plan
- Code 0 (N=64), 8 words, lane 0 of word w = +w → o_loaded=1 after the 8th accept, o_in_ready=0, port 0 reading pos 56 returns 0 one cycle later, pos 0 returns 7.
- Code 1 (N=256) loaded, forward rotate twice then backward once → o_seg=1, and mem[0] equals the value that sat at mem[128] after load.
- Code 2, forward rotate 8 times → o_seg wraps to 0 and contents equal the post-load image; a same-cycle read during a rotation returns pre-rotation data.
- Lane input 0x85 (sign 1, mag 5) → reads 0x7B; input 0x80 → 0. With LLR_BUF_SAT_EN, input 0xFF → -63 (0x41); without the macro it wraps to 0x01.
- In HOLD, drive i_in_valid=1 with i_rot_req and i_release in the same cycle → no word accepted, no rotation, o_loaded=0 and o_in_ready=1 next cycle.
- Assert i_rst after 3 of 32 words → all outputs 0 immediately; after reset, a full 32-word frame loads normally.

Source files
------------

// File: rtl/llr_window_buf_pkg.sv
// Shared types and helpers for the LLR window buffer.
// Holds code-length encodings, N-from-code, width helpers and the load/hold state enum.
package llr_window_buf_pkg;

   localparam int unsigned DEF_LANES = 8;
   localparam int unsigned DEF_LLR_W = 7;
   localparam int unsigned DEF_DEPTH = 1024;
   localparam int unsigned DEF_WIN   = 128;
   localparam int unsigned DEF_NRD   = 4;

   typedef enum logic [1:0] {
      CODE_N16  = 2'd0,
      CODE_N4   = 2'd1,
      CODE_N1   = 2'd2,
      CODE_RSVD = 2'd3
   } code_e;

   typedef enum logic {
      ST_LOAD = 1'b0,
      ST_HOLD = 1'b1
   } state_e;

   // Codeword length for a code selector; reserved maps to full depth but is never latched.
   function automatic int unsigned n_from_code(input code_e code, input int unsigned depth);
      case (code)
         CODE_N16: return depth / 16;
         CODE_N4:  return depth / 4;
         default:  return depth;
      endcase
   endfunction

   // Input lane carries one extra sign bit over the stored two's-complement width.
   function automatic int unsigned lane_width(input int unsigned llr_w);
      return llr_w + 1;
   endfunction

   function automatic int unsigned in_width(input int unsigned lanes, input int unsigned llr_w);
      return lanes * lane_width(llr_w);
   endfunction

endpackage

// File: rtl/llr_sm2tc.sv
// Single-lane sign-magnitude to two's-complement converter.
// LLR_BUF_SAT_EN clips the magnitude to 2^(LLR_W-1)-1; otherwise the result wraps modulo 2^LLR_W.
module llr_sm2tc #(
   parameter int unsigned LLR_W = 7
) (
   input  logic [LLR_W:0]   i_sm,
   output logic [LLR_W-1:0] o_tc
);

   logic             w_sign;
   logic [LLR_W-1:0] w_mag;

   assign w_sign = i_sm[LLR_W];

`ifdef LLR_BUF_SAT_EN
   localparam logic [LLR_W-1:0] MAG_MAX = {1'b0, {(LLR_W-1){1'b1}}};
   assign w_mag = (i_sm[LLR_W-1:0] > MAG_MAX) ? MAG_MAX : i_sm[LLR_W-1:0];
`else
   assign w_mag = i_sm[LLR_W-1:0];
`endif

   assign o_tc = w_sign ? ('0 - w_mag) : w_mag;

endmodule

// File: rtl/llr_window_buf.sv
// LLR staging buffer: framed sign-magnitude load, WIN-step rotation, NRD registered reads.
// Lane conversion honours LLR_BUF_SAT_EN (see llr_sm2tc).
module llr_window_buf
   import llr_window_buf_pkg::*;
#(
   parameter int unsigned LANES = DEF_LANES,
   parameter int unsigned LLR_W = DEF_LLR_W,
   parameter int unsigned DEPTH = DEF_DEPTH,
   parameter int unsigned WIN   = DEF_WIN,
   parameter int unsigned NRD   = DEF_NRD
) (
   input  logic                                i_clk,
   input  logic                                i_rst,
   input  logic [1:0]                          i_code,
   input  logic                                i_in_valid,
   output logic                                o_in_ready,
   input  logic [in_width(LANES, LLR_W)-1:0]   i_in_data,
   output logic                                o_loaded,
   input  logic                                i_release,
   input  logic                                i_rot_req,
   input  logic                                i_rot_dir,
   output logic [$clog2(DEPTH/WIN)-1:0]        o_seg,
   input  logic                                i_rd_en,
   input  logic [NRD*$clog2(WIN)-1:0]          i_rd_pos,
   output logic [NRD*LLR_W-1:0]                o_rd_data,
   output logic                                o_rd_valid
);

   localparam int unsigned LANE_W = lane_width(LLR_W);
   localparam int unsigned POS_W  = $clog2(WIN);
   localparam int unsigned SEG_W  = $clog2(DEPTH / WIN);
   localparam int unsigned IDX_W  = $clog2(DEPTH);
   localparam int unsigned CNT_W  = $clog2(DEPTH / LANES);

   state_e           r_state;
   code_e            r_code;
   logic [CNT_W-1:0] r_cnt;
   logic             r_loaded;
   logic [SEG_W-1:0] r_seg;
   logic [LLR_W-1:0] r_mem     [DEPTH];
   logic [LLR_W-1:0] r_rd_data [NRD];
   logic             r_rd_valid;

   code_e            w_code;
   logic [31:0]      w_n;
   logic [CNT_W-1:0] w_last;
   logic [SEG_W-1:0] w_seg_mask;
   logic             w_in_ready;
   logic             w_accept;
   logic             w_rot_ok;
   logic [LLR_W-1:0] w_conv    [LANES];
   logic [LLR_W-1:0] w_mem_nxt [DEPTH];

   for (genvar k = 0; k < LANES; k++) begin : g_conv
      llr_sm2tc #(.LLR_W(LLR_W)) u_sm2tc (
         .i_sm (i_in_data[k*LANE_W +: LANE_W]),
         .o_tc (w_conv[k])
      );
   end

   // Live i_code governs the first word of a frame; the latched copy governs the rest.
   assign w_code     = (r_state == ST_LOAD && r_cnt == '0) ? code_e'(i_code) : r_code;
   assign w_n        = n_from_code(w_code, DEPTH);
   assign w_last     = CNT_W'(w_n / LANES - 1);
   assign w_seg_mask = SEG_W'(w_n / WIN - 1);
   assign w_in_ready = !i_rst && (r_state == ST_LOAD) && (w_code != CODE_RSVD);
   assign w_accept   = i_in_valid && w_in_ready;
   assign w_rot_ok   = (r_state == ST_HOLD) && i_rot_req && !i_release && (w_n > WIN);

   always_comb begin
      w_mem_nxt = r_mem;
      if (w_accept) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (i < LANES)
               w_mem_nxt[IDX_W'(i)] = w_conv[i];
            else if (i < w_n)
               w_mem_nxt[IDX_W'(i)] = r_mem[IDX_W'(i - LANES)];
         end
      end else if (w_rot_ok) begin
         // N is a power of two, so the modulo reduces to a mask on the rotated index.
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (i < w_n) begin
               if (i_rot_dir)
                  w_mem_nxt[IDX_W'(i)] = r_mem[IDX_W'((i + w_n - WIN) & (w_n - 1))];
               else
                  w_mem_nxt[IDX_W'(i)] = r_mem[IDX_W'((i + WIN) & (w_n - 1))];
            end
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         r_mem <= '{default: '0};
      else
         r_mem <= w_mem_nxt;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state  <= ST_LOAD;
         r_code   <= CODE_N16;
         r_cnt    <= '0;
         r_loaded <= 1'b0;
         r_seg    <= '0;
      end else begin
         case (r_state)
            ST_LOAD: begin
               if (w_accept) begin
                  if (r_cnt == '0)
                     r_code <= code_e'(i_code);
                  if (r_cnt == w_last) begin
                     r_state  <= ST_HOLD;
                     r_loaded <= 1'b1;
                     r_seg    <= '0;
                     r_cnt    <= '0;
                  end else begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
            end
            ST_HOLD: begin
               if (i_release) begin
                  r_state  <= ST_LOAD;
                  r_loaded <= 1'b0;
               end else if (w_rot_ok) begin
                  if (i_rot_dir)
                     r_seg <= (r_seg - SEG_W'(1)) & w_seg_mask;
                  else
                     r_seg <= (r_seg + SEG_W'(1)) & w_seg_mask;
               end
            end
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_rd_valid <= 1'b0;
         r_rd_data  <= '{default: '0};
      end else begin
         r_rd_valid <= i_rd_en;
         if (i_rd_en) begin
            for (int unsigned p = 0; p < NRD; p++)
               r_rd_data[p] <= r_mem[IDX_W'(i_rd_pos[p*POS_W +: POS_W])];
         end
      end
   end

   always_comb begin
      o_rd_data = '0;
      for (int unsigned p = 0; p < NRD; p++)
         o_rd_data[p*LLR_W +: LLR_W] = r_rd_data[p];
   end

   assign o_in_ready = w_in_ready;
   assign o_loaded   = r_loaded;
   assign o_seg      = r_seg;
   assign o_rd_valid = r_rd_valid;

endmodule

// File: tb/tb_llr_window_buf.sv
// Directed bench for llr_window_buf: load, convert, rotate, release and reset scenarios.
// Conversion expectations follow LLR_BUF_SAT_EN.
module tb_llr_window_buf;

   localparam int unsigned LANES = 8;
   localparam int unsigned LLR_W = 7;
   localparam int unsigned DEPTH = 1024;
   localparam int unsigned WIN   = 128;
   localparam int unsigned NRD   = 4;

`ifdef LLR_BUF_SAT_EN
   localparam logic [6:0] EXP_FF = 7'h41;
   localparam logic [6:0] EXP_C0 = 7'h41;
   localparam logic [6:0] EXP_7F = 7'h3F;
`else
   localparam logic [6:0] EXP_FF = 7'h01;
   localparam logic [6:0] EXP_C0 = 7'h40;
   localparam logic [6:0] EXP_7F = 7'h7F;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  code;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_data;
   logic        loaded;
   logic        rls;
   logic        rot_req;
   logic        rot_dir;
   logic [2:0]  seg;
   logic        rd_en;
   logic [27:0] rd_pos;
   logic [27:0] rd_data;
   logic        rd_valid;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   always #5 clk = ~clk;

   llr_window_buf #(
      .LANES (LANES),
      .LLR_W (LLR_W),
      .DEPTH (DEPTH),
      .WIN   (WIN),
      .NRD   (NRD)
   ) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_code     (code),
      .i_in_valid (in_valid),
      .o_in_ready (in_ready),
      .i_in_data  (in_data),
      .o_loaded   (loaded),
      .i_release  (rls),
      .i_rot_req  (rot_req),
      .i_rot_dir  (rot_dir),
      .o_seg      (seg),
      .i_rd_en    (rd_en),
      .i_rd_pos   (rd_pos),
      .o_rd_data  (rd_data),
      .o_rd_valid (rd_valid)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Lane k of word w carries the positive magnitude (w + 16k) mod 128.
   function automatic logic [6:0] dval(input int unsigned w, input int unsigned k);
      return 7'((w + 16 * k) % 128);
   endfunction

   function automatic logic [63:0] word_of(input int unsigned w);
      logic [63:0] d;
      d = '0;
      for (int unsigned k = 0; k < 8; k++)
         d[k*8 +: 8] = {1'b0, dval(w, k)};
      return d;
   endfunction

   // Post-load image: the last word sits at the front, the first word at the back.
   function automatic logic [6:0] load_img(input int unsigned i, input int unsigned n);
      return dval(n / 8 - 1 - i / 8, i % 8);
   endfunction

   function automatic logic [6:0] port_data(input int unsigned p);
      return rd_data[p*7 +: 7];
   endfunction

   task automatic load_frame(input logic [1:0] c, input int unsigned nw, input logic [63:0] last_w);
      for (int unsigned w = 0; w < nw; w++) begin
         code     = c;
         in_valid = 1'b1;
         in_data  = (w == nw - 1) ? last_w : word_of(w);
         @(negedge clk);
      end
      in_valid = 1'b0;
   endtask

   task automatic read4(input int unsigned p0, input int unsigned p1,
                        input int unsigned p2, input int unsigned p3);
      rd_en  = 1'b1;
      rd_pos = {7'(p3), 7'(p2), 7'(p1), 7'(p0)};
      @(negedge clk);
      rd_en  = 1'b0;
   endtask

   task automatic rotate(input logic d);
      rot_req = 1'b1;
      rot_dir = d;
      @(negedge clk);
      rot_req = 1'b0;
   endtask

   task automatic release_frame();
      rls = 1'b1;
      @(negedge clk);
      rls = 1'b0;
   endtask

   initial begin
      rst = 1'b1; code = 2'd0; in_valid = 1'b0; in_data = '0; rls = 1'b0;
      rot_req = 1'b0; rot_dir = 1'b0; rd_en = 1'b0; rd_pos = '0;
      repeat (2) @(negedge clk);
      check_val("rst_ready",  32'(in_ready), 32'd0);
      check_val("rst_loaded", 32'(loaded),   32'd0);
      check_val("rst_seg",    32'(seg),      32'd0);
      check_val("rst_rdata",  32'(rd_data),  32'd0);
      check_val("rst_rvalid", 32'(rd_valid), 32'd0);
      rst = 1'b0;
      #1 check_val("ready_after_rst", 32'(in_ready), 32'd1);
      code = 2'd3;
      #1 check_val("ready_code3", 32'(in_ready), 32'd0);
      code = 2'd0;
      @(negedge clk);

      // Code 0: N=64, 8 words
      load_frame(2'd0, 8, word_of(7));
      check_val("c0_loaded", 32'(loaded),   32'd1);
      check_val("c0_ready",  32'(in_ready), 32'd0);
      check_val("c0_seg",    32'(seg),      32'd0);
      read4(56, 0, 63, 7);
      check_val("c0_rvalid", 32'(rd_valid),     32'd1);
      check_val("c0_pos56",  32'(port_data(0)), 32'd0);
      check_val("c0_pos0",   32'(port_data(1)), 32'd7);
      check_val("c0_pos63",  32'(port_data(2)), 32'd112);
      check_val("c0_pos7",   32'(port_data(3)), 32'd119);
      rotate(1'b0);
      check_val("c0_rot_ignored_seg", 32'(seg), 32'd0);
      rd_pos = {7'd5, 7'd5, 7'd5, 7'd5};
      @(negedge clk);
      check_val("c0_hold_rvalid", 32'(rd_valid),     32'd0);
      check_val("c0_hold_rdata",  32'(port_data(1)), 32'd7);
      read4(0, 0, 0, 0);
      check_val("c0_rot_ignored_data", 32'(port_data(0)), 32'd7);
      release_frame();
      check_val("c0_rel_loaded", 32'(loaded),   32'd0);
      check_val("c0_rel_ready",  32'(in_ready), 32'd1);

      // Conversion through the front word of a second code-0 frame
      load_frame(2'd0, 8, 64'h7F7F7F7F_C0FF8085);
      read4(0, 1, 2, 3);
      check_val("cv_85", 32'(port_data(0)), 32'h7B);
      check_val("cv_80", 32'(port_data(1)), 32'h00);
      check_val("cv_FF", 32'(port_data(2)), 32'(EXP_FF));
      check_val("cv_C0", 32'(port_data(3)), 32'(EXP_C0));
      read4(4, 7, 8, 56);
      check_val("cv_7F",    32'(port_data(0)), 32'(EXP_7F));
      check_val("cv_7F_l7", 32'(port_data(1)), 32'(EXP_7F));
      check_val("cv_w6",    32'(port_data(2)), 32'(load_img(8, 64)));
      release_frame();

      // Code 1: N=256, two segments
      load_frame(2'd1, 32, word_of(31));
      check_val("c1_loaded", 32'(loaded), 32'd1);
      read4(0, 1, 64, 127);
      check_val("c1_pos0",   32'(port_data(0)), 32'(load_img(0, 256)));
      check_val("c1_pos127", 32'(port_data(3)), 32'(load_img(127, 256)));
      rotate(1'b0);
      check_val("c1_seg_f1", 32'(seg), 32'd1);
      rotate(1'b0);
      check_val("c1_seg_f2", 32'(seg), 32'd0);
      rotate(1'b1);
      check_val("c1_seg_b1", 32'(seg), 32'd1);
      read4(0, 1, 64, 127);
      check_val("c1_rot_pos0",   32'(port_data(0)), 32'(load_img(128, 256)));
      check_val("c1_rot_pos1",   32'(port_data(1)), 32'(load_img(129, 256)));
      check_val("c1_rot_pos64",  32'(port_data(2)), 32'(load_img(192, 256)));
      check_val("c1_rot_pos127", 32'(port_data(3)), 32'(load_img(255, 256)));
      release_frame();

      // Code 2: N=1024, eight segments
      load_frame(2'd2, 128, word_of(127));
      rd_en = 1'b1; rd_pos = {7'd127, 7'd100, 7'd5, 7'd0};
      rotate(1'b0);
      rd_en = 1'b0;
      check_val("c2_seg_f1",    32'(seg),          32'd1);
      check_val("c2_pre_pos0",  32'(port_data(0)), 32'(load_img(0, 1024)));
      check_val("c2_pre_pos5",  32'(port_data(1)), 32'(load_img(5, 1024)));
      check_val("c2_pre_pos100",32'(port_data(2)), 32'(load_img(100, 1024)));
      read4(0, 5, 100, 127);
      check_val("c2_r1_pos0",   32'(port_data(0)), 32'(load_img(128, 1024)));
      for (int unsigned r = 0; r < 7; r++) rotate(1'b0);
      check_val("c2_seg_wrap", 32'(seg), 32'd0);
      read4(0, 5, 100, 127);
      check_val("c2_wrap_pos0",   32'(port_data(0)), 32'(load_img(0, 1024)));
      check_val("c2_wrap_pos5",   32'(port_data(1)), 32'(load_img(5, 1024)));
      check_val("c2_wrap_pos100", 32'(port_data(2)), 32'(load_img(100, 1024)));
      check_val("c2_wrap_pos127", 32'(port_data(3)), 32'(load_img(127, 1024)));
      rotate(1'b1);
      check_val("c2_seg_b1", 32'(seg), 32'd7);
      read4(0, 1, 127, 64);
      check_val("c2_b1_pos0",   32'(port_data(0)), 32'(load_img(896, 1024)));
      check_val("c2_b1_pos127", 32'(port_data(2)), 32'(load_img(1023, 1024)));

      // Release, rotate and a valid word together in HOLD: release wins
      in_valid = 1'b1; in_data = word_of(99); rot_req = 1'b1; rot_dir = 1'b0; rls = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; rot_req = 1'b0; rls = 1'b0;
      check_val("rel_pri_loaded", 32'(loaded),   32'd0);
      check_val("rel_pri_ready",  32'(in_ready), 32'd1);
      read4(0, 1, 127, 64);
      check_val("rel_pri_pos0", 32'(port_data(0)), 32'(load_img(896, 1024)));
      check_val("rel_pri_pos1", 32'(port_data(1)), 32'(load_img(897, 1024)));

      // Reset after 3 of 32 code-1 words
      for (int unsigned w = 0; w < 3; w++) begin
         code = 2'd1; in_valid = 1'b1; in_data = word_of(w);
         rd_en = 1'b1; rd_pos = '0;
         @(negedge clk);
      end
      rst = 1'b1;
      #1;
      check_val("mid_rst_ready",  32'(in_ready), 32'd0);
      check_val("mid_rst_loaded", 32'(loaded),   32'd0);
      check_val("mid_rst_seg",    32'(seg),      32'd0);
      check_val("mid_rst_rdata",  32'(rd_data),  32'd0);
      check_val("mid_rst_rvalid", 32'(rd_valid), 32'd0);
      in_valid = 1'b0; rd_en = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      load_frame(2'd1, 32, word_of(31));
      check_val("post_rst_loaded", 32'(loaded), 32'd1);
      read4(0, 9, 127, 100);
      check_val("post_rst_pos0",   32'(port_data(0)), 32'(load_img(0, 256)));
      check_val("post_rst_pos9",   32'(port_data(1)), 32'(load_img(9, 256)));
      check_val("post_rst_pos127", 32'(port_data(2)), 32'(load_img(127, 256)));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
